// File: rtl/data_mem_responder_if.sv
// Request/response bus between the CPU memory-access FSM (master) and the
// data-memory responder (slave).
interface data_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_write;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_write, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data RAM behind a valid/ready request/response handshake, with a fixed
// number of wait states inserted before each access.
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus,
  output logic       busy
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]        WAIT_L  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              rsp_write_q, rsp_write_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic              in_range;

  assign mem_idx  = addr_q[IDX_W-1:0];
  assign in_range = ({1'b0, addr_q} < DEPTH_L);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_write_d = rsp_write_q;
    mem_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_L;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        rsp_write_d = write_q;
        state_d     = ST_RESP;
        if (in_range) begin
          err_d = 1'b0;
          if (write_q) begin
            mem_we  = 1'b1;
            rdata_d = '0;
          end else begin
            rdata_d = mem[mem_idx];
          end
        end else begin
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_write_q <= rsp_write_d;
    end
  end

  // Reset on the ACCESS closing edge suppresses the store.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_idx] <= wdata_q;
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders (W=2/D=256, W=0/D=256, W=2/D=128).
module tb_data_mem_responder;

  logic clk;
  logic reset;

  logic       tv  [3];
  logic       tw  [3];
  logic       trr [3];
  logic [7:0] ta  [3];
  logic [7:0] td  [3];

  logic       o_rr   [3];
  logic       o_rv   [3];
  logic       o_rw   [3];
  logic       o_re   [3];
  logic       o_busy [3];
  logic [7:0] o_rd   [3];

  int checks;
  int errors;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 1) ? 0 : 2;
    localparam int D = (g == 2) ? 128 : 256;

    data_mem_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    assign bus.req_valid = tv[g];
    assign bus.req_write = tw[g];
    assign bus.req_addr  = ta[g];
    assign bus.req_wdata = td[g];
    assign bus.rsp_ready = trr[g];
    assign o_rr[g]       = bus.req_ready;
    assign o_rv[g]       = bus.rsp_valid;
    assign o_rw[g]       = bus.rsp_write;
    assign o_re[g]       = bus.rsp_err;
    assign o_rd[g]       = bus.rsp_rdata;

    data_mem_responder #(
      .ADDR_W(8),
      .DATA_W(8),
      .DEPTH(D),
      .WAIT_CYCLES(W)
    ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus),
      .busy (o_busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with rsp_ready high; lat = edges from accept to rsp_valid.
  task automatic txn(input int k, input logic w, input logic [7:0] a, input logic [7:0] d,
                     output int lat, output logic [7:0] rd, output logic er, output logic wr);
    int guard;
    tw[k] = w; ta[k] = a; td[k] = d; trr[k] = 1'b1; tv[k] = 1'b1;
    guard = 0;
    while (o_rr[k] !== 1'b1 && guard < 50) begin step(); guard++; end
    step();
    tv[k] = 1'b0;
    lat = 0;
    while (o_rv[k] !== 1'b1 && lat < 50) begin step(); lat++; end
    checks++;
    if (lat >= 50) begin
      errors++;
      $display("FAIL txn_timeout inst=%0d addr=%h: no rsp_valid within 50 cycles", k, a);
    end
    rd = o_rd[k]; er = o_re[k]; wr = o_rw[k];
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_rr[k] !== 1'b1 || o_rv[k] !== 1'b0 || o_rd[k] !== 8'h00 ||
          o_rw[k] !== 1'b0 || o_re[k] !== 1'b0 || o_busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_values inst=%0d got rr=%b rv=%b rd=%h rw=%b re=%b busy=%b expected 1 0 00 0 0 0",
                 k, o_rr[k], o_rv[k], o_rd[k], o_rw[k], o_re[k], o_busy[k]);
      end
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_store_load();
    int lat; logic [7:0] rd; logic er, wr;
    txn(0, 1'b1, 8'h10, 8'hA5, lat, rd, er, wr);
    checks++;
    if (lat !== 3 || rd !== 8'h00 || er !== 1'b0 || wr !== 1'b1) begin
      errors++;
      $display("FAIL store_0x10 got lat=%0d rd=%h err=%b wr=%b expected 3 00 0 1", lat, rd, er, wr);
    end
    txn(0, 1'b0, 8'h10, 8'h00, lat, rd, er, wr);
    checks++;
    if (lat !== 3 || rd !== 8'hA5 || er !== 1'b0 || wr !== 1'b0) begin
      errors++;
      $display("FAIL load_0x10 got lat=%0d rd=%h err=%b wr=%b expected 3 a5 0 0", lat, rd, er, wr);
    end
  endtask

  task automatic test_zero_wait();
    int lat; logic [7:0] rd; logic er, wr;
    int prev, accepts, guard;
    txn(1, 1'b1, 8'h00, 8'h3C, lat, rd, er, wr);
    checks++;
    if (lat !== 1 || wr !== 1'b1) begin
      errors++;
      $display("FAIL w0_store got lat=%0d wr=%b expected 1 1", lat, wr);
    end
    txn(1, 1'b0, 8'h00, 8'h00, lat, rd, er, wr);
    checks++;
    if (lat !== 1 || rd !== 8'h3C || er !== 1'b0) begin
      errors++;
      $display("FAIL w0_load got lat=%0d rd=%h err=%b expected 1 3c 0", lat, rd, er);
    end
    tw[1] = 1'b0; ta[1] = 8'h00; trr[1] = 1'b1; tv[1] = 1'b1;
    prev = -1; accepts = 0;
    for (int t = 0; t < 12; t++) begin
      if (o_rr[1] === 1'b1) begin
        if (prev >= 0) begin
          checks++;
          if (t - prev !== 3) begin
            errors++;
            $display("FAIL b2b_spacing got %0d expected 3", t - prev);
          end
        end
        prev = t;
        accepts++;
      end
      if (o_rv[1] === 1'b1) begin
        checks++;
        if (o_rd[1] !== 8'h3C) begin
          errors++;
          $display("FAIL b2b_rdata got %h expected 3c", o_rd[1]);
        end
      end
      step();
    end
    checks++;
    if (accepts !== 4) begin
      errors++;
      $display("FAIL b2b_accepts got %0d expected 4", accepts);
    end
    tv[1] = 1'b0;
    guard = 0;
    while (o_busy[1] !== 1'b0 && guard < 20) begin step(); guard++; end
  endtask

  task automatic test_backpressure();
    int guard;
    tw[0] = 1'b0; ta[0] = 8'h10; trr[0] = 1'b0; tv[0] = 1'b1;
    guard = 0;
    while (o_rr[0] !== 1'b1 && guard < 50) begin step(); guard++; end
    step();
    guard = 0;
    while (o_rv[0] !== 1'b1 && guard < 50) begin step(); guard++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_rv[0] !== 1'b1 || o_rd[0] !== 8'hA5 || o_rr[0] !== 1'b0 || o_re[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d got rv=%b rd=%h rr=%b err=%b expected 1 a5 0 0",
                 i, o_rv[0], o_rd[0], o_rr[0], o_re[0]);
      end
      step();
    end
    trr[0] = 1'b1;
    step();
    checks++;
    if (o_rv[0] !== 1'b0 || o_rr[0] !== 1'b1 || o_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rv=%b rr=%b busy=%b expected 0 1 0", o_rv[0], o_rr[0], o_busy[0]);
    end
    step();
    tv[0] = 1'b0;
    checks++;
    if (o_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_accept got busy=%b expected 1", o_busy[0]);
    end
    guard = 0;
    while (o_rv[0] !== 1'b1 && guard < 50) begin step(); guard++; end
    checks++;
    if (o_rd[0] !== 8'hA5) begin
      errors++;
      $display("FAIL bp_second_load got rd=%h expected a5", o_rd[0]);
    end
    step();
  endtask

  task automatic test_out_of_range();
    int lat; logic [7:0] rd; logic er, wr;
    txn(2, 1'b1, 8'h00, 8'h11, lat, rd, er, wr);
    checks++;
    if (er !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL oor_seed got err=%b lat=%0d expected 0 3", er, lat);
    end
    txn(2, 1'b1, 8'h80, 8'hFF, lat, rd, er, wr);
    checks++;
    if (er !== 1'b1 || rd !== 8'h00 || wr !== 1'b1) begin
      errors++;
      $display("FAIL oor_store got err=%b rd=%h wr=%b expected 1 00 1", er, rd, wr);
    end
    txn(2, 1'b0, 8'h80, 8'h00, lat, rd, er, wr);
    checks++;
    if (er !== 1'b1 || rd !== 8'h00 || wr !== 1'b0) begin
      errors++;
      $display("FAIL oor_load got err=%b rd=%h wr=%b expected 1 00 0", er, rd, wr);
    end
    txn(2, 1'b0, 8'h00, 8'h00, lat, rd, er, wr);
    checks++;
    if (er !== 1'b0 || rd !== 8'h11) begin
      errors++;
      $display("FAIL oor_alias got err=%b rd=%h expected 0 11", er, rd);
    end
  endtask

  task automatic test_reset_mid_wait();
    int lat, guard; logic [7:0] rd; logic er, wr;
    txn(0, 1'b1, 8'h20, 8'h5A, lat, rd, er, wr);
    tw[0] = 1'b1; ta[0] = 8'h20; td[0] = 8'h77; trr[0] = 1'b1; tv[0] = 1'b1;
    guard = 0;
    while (o_rr[0] !== 1'b1 && guard < 50) begin step(); guard++; end
    step();
    tv[0] = 1'b0;
    checks++;
    if (o_busy[0] !== 1'b1 || o_rr[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait_busy got busy=%b rr=%b expected 1 0", o_busy[0], o_rr[0]);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (o_rr[0] !== 1'b1 || o_rv[0] !== 1'b0 || o_rd[0] !== 8'h00 ||
        o_rw[0] !== 1'b0 || o_re[0] !== 1'b0 || o_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_wait_reset got rr=%b rv=%b rd=%h rw=%b re=%b busy=%b expected 1 0 00 0 0 0",
               o_rr[0], o_rv[0], o_rd[0], o_rw[0], o_re[0], o_busy[0]);
    end
    txn(0, 1'b0, 8'h20, 8'h00, lat, rd, er, wr);
    checks++;
    if (rd !== 8'h5A || er !== 1'b0) begin
      errors++;
      $display("FAIL aborted_store got rd=%h err=%b expected 5a 0", rd, er);
    end
  endtask

  task automatic test_top_address();
    int lat; logic [7:0] rd; logic er, wr;
    txn(0, 1'b1, 8'hFF, 8'hC3, lat, rd, er, wr);
    checks++;
    if (er !== 1'b0) begin
      errors++;
      $display("FAIL top_store got err=%b expected 0", er);
    end
    txn(0, 1'b0, 8'hFF, 8'h00, lat, rd, er, wr);
    checks++;
    if (rd !== 8'hC3 || er !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL top_load got rd=%h err=%b lat=%0d expected c3 0 3", rd, er, lat);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tv[k] = 1'b0; tw[k] = 1'b0; trr[k] = 1'b0; ta[k] = 8'h00; td[k] = 8'h00;
    end
    test_reset();
    test_store_load();
    test_zero_wait();
    test_backpressure();
    test_out_of_range();
    test_reset_mid_wait();
    test_top_address();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
